// File: rtl/video_src_switch.sv
// N-source video output selector: frame-aligned glitch-free switching with a muted
// settling window, optional per-source composite sync and colour bit-replication.
module video_src_switch #(
    parameter int unsigned NUM_SRC     = 2,
    parameter int unsigned SEL_W       = 1,
    parameter int unsigned IN_BITS     = 4,
    parameter int unsigned OUT_BITS    = 10,
    parameter int unsigned MUTE_FRAMES = 2,
    parameter int unsigned VS_TIMEOUT  = 1048576
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_SRC*IN_BITS-1:0] src_r,
    input  logic [NUM_SRC*IN_BITS-1:0] src_g,
    input  logic [NUM_SRC*IN_BITS-1:0] src_b,
    input  logic [NUM_SRC-1:0]         src_hs_n,
    input  logic [NUM_SRC-1:0]         src_vs_n,
    input  logic [NUM_SRC-1:0]         csync_en,
    input  logic [SEL_W-1:0]           sel,
    output logic [OUT_BITS-1:0]        out_r,
    output logic [OUT_BITS-1:0]        out_g,
    output logic [OUT_BITS-1:0]        out_b,
    output logic                       out_hs,
    output logic                       out_vs,
    output logic                       out_blank_n,
    output logic [SEL_W-1:0]           active_sel,
    output logic                       switching
);

    localparam int unsigned TMR_W = (VS_TIMEOUT > 1) ? $clog2(VS_TIMEOUT) : 1;
    localparam int unsigned CNT_W = $clog2(MUTE_FRAMES + 1);
    localparam int unsigned PIX_W = 3 * OUT_BITS + 3;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(VS_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUTE_FRAMES - 1);
    // Pixel word {r, g, b, hs, vs, blank_n}; idle value has syncs high and blank asserted.
    localparam logic [PIX_W-1:0] PIX_RST  = PIX_W'(3'b110);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_VS, ST_MUTE} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   active_q, active_d;
    logic [SEL_W-1:0]   target_q, target_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   frame_q, frame_d;
    logic               switching_q, switching_d;
    logic               mute_q, mute_d;
    logic               init_q, init_d;
    logic [NUM_SRC-1:0] vs_prev_q, vs_prev_d;
    logic [PIX_W-1:0]   s1_q, s1_d;
    logic [PIX_W-1:0]   s2_q, s2_d;

    logic               sel_valid;
    logic [NUM_SRC-1:0] vs_fall;
    logic               fall_sel, fall_tgt, fall_act;
    logic [IN_BITS-1:0] pick_r, pick_g, pick_b;
    logic               pick_hs, pick_vs, pick_cs;
    logic               sync_hs, sync_vs;

    function automatic logic [OUT_BITS-1:0] expand(input logic [IN_BITS-1:0] c);
        logic [OUT_BITS-1:0] e;
        e = '0;
        for (int unsigned i = 0; i < OUT_BITS; i++) begin
            e[OUT_BITS-1-i] = c[IN_BITS-1-(i % IN_BITS)];
        end
        return e;
    endfunction

    // Source selection and vsync falling-edge lookup for sel / target / active
    always_comb begin
        sel_valid = 32'(sel) < NUM_SRC;
        vs_fall   = vs_prev_q & ~src_vs_n;
        vs_prev_d = src_vs_n;
        fall_sel  = 1'b0;
        fall_tgt  = 1'b0;
        fall_act  = 1'b0;
        pick_r    = '0;
        pick_g    = '0;
        pick_b    = '0;
        pick_hs   = 1'b1;
        pick_vs   = 1'b1;
        pick_cs   = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (SEL_W'(k) == sel)      fall_sel = vs_fall[k];
            if (SEL_W'(k) == target_q) fall_tgt = vs_fall[k];
            if (SEL_W'(k) == active_q) begin
                fall_act = vs_fall[k];
                pick_r   = src_r[k*IN_BITS +: IN_BITS];
                pick_g   = src_g[k*IN_BITS +: IN_BITS];
                pick_b   = src_b[k*IN_BITS +: IN_BITS];
                pick_hs  = src_hs_n[k];
                pick_vs  = src_vs_n[k];
                pick_cs  = csync_en[k];
            end
        end
    end

    // Switch controller
    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        target_d    = target_q;
        timer_d     = timer_q;
        frame_d     = frame_q;
        switching_d = switching_q;
        mute_d      = mute_q;
        init_d      = init_q;
        case (state_q)
            ST_IDLE: begin
                if (init_q) begin
                    init_d      = 1'b0;
                    frame_d     = '0;
                    switching_d = 1'b1;
                    mute_d      = 1'b1;
                    state_d     = ST_MUTE;
                end else if (sel_valid && sel != active_q) begin
                    target_d    = sel;
                    timer_d     = '0;
                    switching_d = 1'b1;
                    state_d     = ST_WAIT_VS;
                end
            end
            ST_WAIT_VS: begin
                timer_d = timer_q + TMR_W'(1);
                if (sel_valid && sel == active_q) begin
                    // A cancel during an unfinished mute window resumes that window.
                    state_d     = mute_q ? ST_MUTE : ST_IDLE;
                    switching_d = mute_q;
                end else if (sel_valid && sel != target_q) begin
                    target_d = sel;
                    timer_d  = '0;
                    if (fall_sel) begin
                        active_d = sel;
                        frame_d  = '0;
                        mute_d   = 1'b1;
                        state_d  = ST_MUTE;
                    end
                end else if (fall_tgt || timer_q == TMR_LAST) begin
                    active_d = target_q;
                    frame_d  = '0;
                    mute_d   = 1'b1;
                    state_d  = ST_MUTE;
                end
            end
            ST_MUTE: begin
                if (sel_valid && sel != active_q) begin
                    target_d = sel;
                    timer_d  = '0;
                    state_d  = ST_WAIT_VS;
                end else if (fall_act) begin
                    if (frame_q == CNT_LAST) begin
                        switching_d = 1'b0;
                        mute_d      = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        frame_d = frame_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pipeline: stage 1 applies mute/blank and sync mode, stage 2 drives the pins
    always_comb begin
        sync_hs = pick_cs ? ~(pick_hs ^ pick_vs) : pick_hs;
        sync_vs = pick_cs ? 1'b1 : pick_vs;
        s1_d    = {mute_q ? '0 : expand(pick_r),
                   mute_q ? '0 : expand(pick_g),
                   mute_q ? '0 : expand(pick_b),
                   sync_hs, sync_vs, ~mute_q};
        s2_d    = s1_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            active_q    <= '0;
            target_q    <= '0;
            timer_q     <= '0;
            frame_q     <= '0;
            switching_q <= 1'b0;
            mute_q      <= 1'b1;
            init_q      <= 1'b1;
            vs_prev_q   <= '1;
            s1_q        <= PIX_RST;
            s2_q        <= PIX_RST;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            target_q    <= target_d;
            timer_q     <= timer_d;
            frame_q     <= frame_d;
            switching_q <= switching_d;
            mute_q      <= mute_d;
            init_q      <= init_d;
            vs_prev_q   <= vs_prev_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
        end
    end

    assign out_r       = s2_q[PIX_W-1 -: OUT_BITS];
    assign out_g       = s2_q[PIX_W-1-OUT_BITS -: OUT_BITS];
    assign out_b       = s2_q[3 +: OUT_BITS];
    assign out_hs      = s2_q[2];
    assign out_vs      = s2_q[1];
    assign out_blank_n = s2_q[0];
    assign active_sel  = active_q;
    assign switching   = switching_q;

endmodule
